uart_deserialized: RTL

- UART receive-side counterpart of the word serializer; turns a stream of 8N1 UART bytes into one DATA_WIDTH_BYTES-wide word.
- The first received byte lands in data_out[7:0]. This matches the transmitter's LSB-first byte order, so serialized words round-trip unchanged.
- Contains its own bit-level receiver (synchronizer, mid-bit sampling) plus word-assembly and inter-byte timeout logic.
- Sits between the host-facing rx pin and command/config logic.

---
 rtl/uart_deserialized.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_deserialized.sv
// 8N1 UART receiver that assembles DATA_WIDTH_BYTES bytes into one word, first byte in the LSBs.
// Includes a 2-flop input synchronizer, mid-bit sampling, and an inter-byte timeout that drops partial words.
module uart_deserialized #(
   parameter int DATA_WIDTH_BYTES = 6,
   parameter int CLKS_PER_BIT     = 434,
   parameter int TIMEOUT_CLKS     = 43400
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx_in,
   output logic [DATA_WIDTH_BYTES*8-1:0] data_out,
   output logic                          data_valid,
   output logic                          frame_error,
   output logic                          timeout,
   output logic                          busy
);
   localparam int W  = DATA_WIDTH_BYTES * 8;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam int NW = $clog2(DATA_WIDTH_BYTES + 1);
   localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);
   localparam logic [NW-1:0] LAST_BYTE = NW'(DATA_WIDTH_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_RECOVER
   } state_t;

   state_t          state_q, state_d;
   logic            rx_meta_q, rx_s_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      byte_q, byte_d;
   logic [W-1:0]    shift_q, shift_d;
   logic [NW-1:0]   count_q, count_d;
   logic [TW-1:0]   to_cnt_q, to_cnt_d;
   logic [W-1:0]    dout_q, dout_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            tout_q, tout_d;
   logic            accept;
   logic [W-1:0]    word_asm;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         byte_q    <= '0;
         shift_q   <= '0;
         count_q   <= '0;
         to_cnt_q  <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         tout_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx_in;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         shift_q   <= shift_d;
         count_q   <= count_d;
         to_cnt_q  <= to_cnt_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         tout_q    <= tout_d;
      end
   end

   // Each byte is written straight into its final lane, equivalent to shifting in LSB-first.
   always_comb begin
      word_asm = shift_q;
      for (int k = 0; k < DATA_WIDTH_BYTES; k++) begin
         if (count_q == NW'(k)) begin
            word_asm[8*k +: 8] = byte_q;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      shift_d  = shift_q;
      count_d  = count_q;
      to_cnt_d = to_cnt_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      tout_d   = 1'b0;
      accept   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == MID_CNT) begin
               cnt_d = '0;
               bit_d = '0;
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d  = '0;
               byte_d = {rx_s_q, byte_q[7:1]};
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  accept  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  count_d = '0;
                  shift_d = '0;
                  state_d = S_RECOVER;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RECOVER: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         shift_d = word_asm;
         if (count_q == LAST_BYTE) begin
            dout_d  = word_asm;
            valid_d = 1'b1;
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end

      // Timeout overrides a same-cycle start edge: the new byte then opens a fresh word.
      if (state_q == S_IDLE && count_q != '0) begin
         if (to_cnt_q == TO_LAST) begin
            tout_d   = 1'b1;
            count_d  = '0;
            shift_d  = '0;
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end else begin
         to_cnt_d = '0;
      end
   end

   assign data_out    = dout_q;
   assign data_valid  = valid_q;
   assign frame_error = ferr_q;
   assign timeout     = tout_q;
   assign busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule
